// File: rtl/alu_exec_if.sv
// Execute-stage bus: the uop issue side from decode and the writeback side
// toward the register file, together with the retired-op counter.
interface alu_exec_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 32
) ();
  logic             uop_valid_in;
  logic             uop_ready_out;
  logic             uop_is_add;
  logic [1:0]       ctrl_adder;
  logic             uop_is_logic;
  logic [2:0]       ctrl_logic;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic [XLEN-1:0]  imm_data;
  logic [TAG_W-1:0] rd_tag_in;
  logic             wb_valid;
  logic             wb_ready;
  logic [XLEN-1:0]  wb_result;
  logic [TAG_W-1:0] wb_rd_tag;
  logic             wb_exc;
  logic [CNT_W-1:0] retired_cnt;

  modport master (
    output uop_valid_in, uop_is_add, ctrl_adder, uop_is_logic, ctrl_logic,
           rs1_data, rs2_data, imm_data, rd_tag_in, wb_ready,
    input  uop_ready_out, wb_valid, wb_result, wb_rd_tag, wb_exc, retired_cnt
  );

  modport slave (
    input  uop_valid_in, uop_is_add, ctrl_adder, uop_is_logic, ctrl_logic,
           rs1_data, rs2_data, imm_data, rd_tag_in, wb_ready,
    output uop_ready_out, wb_valid, wb_result, wb_rd_tag, wb_exc, retired_cnt
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Integer execute stage: adder/logic result computed at issue, queued in a
// 2-entry in-order buffer toward writeback, with a retired-op counter.
module alu_exec_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic      clk,
  input  logic      reset,
  alu_exec_if.slave bus
);
  logic [XLEN-1:0]  buf_result [2];
  logic [TAG_W-1:0] buf_tag    [2];
  logic             buf_exc    [2];
  logic             head;
  logic [1:0]       count;
  logic [CNT_W-1:0] retired;

  logic             accept;
  logic             xfer;
  logic             tail;
  logic             legal;
  logic [XLEN-1:0]  alu_result;
  logic [XLEN-1:0]  logic_opb;

  assign bus.uop_ready_out = (count != 2'd2);
  assign bus.wb_valid      = (count != 2'd0);
  assign accept            = bus.uop_valid_in & bus.uop_ready_out;
  assign xfer              = bus.wb_valid & bus.wb_ready;
  // With count==1 the free slot is the one after head; with count==0 it is head.
  assign tail              = head ^ (count == 2'd1);

  // Empty buffer presents zeros so wb_* never leak stale entries.
  assign bus.wb_result   = bus.wb_valid ? buf_result[head] : '0;
  assign bus.wb_rd_tag   = bus.wb_valid ? buf_tag[head]    : '0;
  assign bus.wb_exc      = bus.wb_valid ? buf_exc[head]    : 1'b0;
  assign bus.retired_cnt = retired;

  assign logic_opb = bus.ctrl_logic[2] ? bus.imm_data : bus.rs2_data;

  always_comb begin
    legal      = 1'b0;
    alu_result = '0;
    if (bus.uop_is_add && !bus.uop_is_logic) begin
      legal = (bus.ctrl_adder != 2'b00);
      case (bus.ctrl_adder)
        2'b01:   alu_result = bus.rs1_data + bus.rs2_data;
        2'b10:   alu_result = bus.rs1_data - bus.rs2_data;
        2'b11:   alu_result = bus.rs1_data + bus.imm_data;
        default: alu_result = '0;
      endcase
    end else if (bus.uop_is_logic && !bus.uop_is_add) begin
      // Low two bits pick the operation, bit 2 swaps rs2 for the immediate.
      legal = (bus.ctrl_logic[1:0] != 2'b00);
      case (bus.ctrl_logic[1:0])
        2'b01:   alu_result = bus.rs1_data | logic_opb;
        2'b10:   alu_result = bus.rs1_data ^ logic_opb;
        2'b11:   alu_result = bus.rs1_data & logic_opb;
        default: alu_result = '0;
      endcase
    end
    if (!legal) alu_result = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head          <= 1'b0;
      count         <= 2'd0;
      retired       <= '0;
      buf_result[0] <= '0;
      buf_result[1] <= '0;
      buf_tag[0]    <= '0;
      buf_tag[1]    <= '0;
      buf_exc[0]    <= 1'b0;
      buf_exc[1]    <= 1'b0;
    end else begin
      if (accept) begin
        buf_result[tail] <= alu_result;
        buf_tag[tail]    <= bus.rd_tag_in;
        buf_exc[tail]    <= ~legal;
      end
      if (xfer) begin
        head    <= ~head;
        retired <= retired + CNT_W'(1);
      end
      if (accept && !xfer)      count <= count + 2'd1;
      else if (xfer && !accept) count <= count - 2'd1;
    end
  end
endmodule
